// File: rtl/pc_prt_ctrl.sv
// PRT sequencer for the I/Q pulse-compression matched filter: TX/RX timing, input
// gating, range-bin alignment with the filter output, and a per-PRT peak search.
module pc_prt_ctrl #(
    parameter int WIDTH    = 12,
    parameter int TAPS     = 64,
    parameter int ABS_W    = 73,
    parameter int PRT_LEN  = 1000,
    parameter int TX_LEN   = 64,
    parameter int RX_START = 80,
    parameter int RX_LEN   = 512,
    parameter int PC_LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] adc_I,
    input  logic [WIDTH-1:0] adc_Q,
    output logic [WIDTH-1:0] pc_in_I,
    output logic [WIDTH-1:0] pc_in_Q,
    input  logic [ABS_W-1:0] pc_abs2,
    output logic             tx_trig,
    output logic             rx_gate,
    output logic             flush,
    output logic             pc_valid,
    output logic [9:0]       range_bin,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic [ABS_W-1:0] peak_val,
    output logic [9:0]       peak_bin,
    output logic [15:0]      prt_index,
    output logic             overrun,
    output logic             busy
);

    localparam int NBINS     = RX_LEN + TAPS - 1;
    localparam int CNT_W     = $clog2(PRT_LEN);
    localparam int V_START_I = RX_START + 1 + PC_LAT;

    localparam logic [CNT_W-1:0] TX_END  = CNT_W'(TX_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(RX_START - 1);
    localparam logic [CNT_W-1:0] RX_END  = CNT_W'(RX_START + RX_LEN - 1);
    localparam logic [CNT_W-1:0] FL_END  = CNT_W'(RX_START + RX_LEN + TAPS - 2);
    localparam logic [CNT_W-1:0] PRT_END = CNT_W'(PRT_LEN - 1);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_START_I);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_START_I + NBINS - 1);
    localparam logic [9:0]       LAST_BIN = 10'(NBINS - 1);

    generate
        if (TX_LEN > RX_START || RX_START + RX_LEN + TAPS + PC_LAT > PRT_LEN - 1) begin : g_illegal
            $error("pc_prt_ctrl: illegal PRT timing parameters");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, TX, GAP, RX, FLUSH, TAIL} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] prt_cnt, cnt_next;
    logic             bin_valid_next;
    logic [ABS_W-1:0] run_max, cand_val;
    logic [9:0]       run_bin, cand_bin;
    logic             result_load;

    // The end of a PRT takes priority over the phase transitions, so a PRT always runs full length.
    always_comb begin
        state_next = state;
        cnt_next   = prt_cnt + 1'b1;
        if (state == IDLE) begin
            cnt_next = '0;
            if (en) state_next = TX;
        end else if (prt_cnt == PRT_END) begin
            cnt_next   = '0;
            state_next = en ? TX : IDLE;
        end else begin
            case (state)
                TX:      if (prt_cnt == TX_END)  state_next = (TX_LEN == RX_START) ? RX : GAP;
                GAP:     if (prt_cnt == GAP_END) state_next = RX;
                RX:      if (prt_cnt == RX_END)  state_next = FLUSH;
                FLUSH:   if (prt_cnt == FL_END)  state_next = TAIL;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prt_cnt <= '0;
        end else begin
            state   <= state_next;
            prt_cnt <= cnt_next;
        end
    end

    assign bin_valid_next = (state_next != IDLE) && (cnt_next >= V_START) && (cnt_next <= V_END);

    // Decoding from the next state keeps the strobes registered yet aligned with prt_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_trig   <= 1'b0;
            rx_gate   <= 1'b0;
            flush     <= 1'b0;
            busy      <= 1'b0;
            pc_valid  <= 1'b0;
            range_bin <= '0;
            pc_in_I   <= '0;
            pc_in_Q   <= '0;
            prt_index <= '0;
        end else begin
            tx_trig   <= (state_next == TX);
            rx_gate   <= (state_next == RX);
            flush     <= (state_next == FLUSH);
            busy      <= (state_next != IDLE);
            pc_valid  <= bin_valid_next;
            range_bin <= bin_valid_next ? 10'(cnt_next - V_START) : 10'd0;
            pc_in_I   <= (state == RX) ? adc_I : '0;
            pc_in_Q   <= (state == RX) ? adc_Q : '0;
            if (state != IDLE && prt_cnt == PRT_END) prt_index <= prt_index + 1'b1;
        end
    end

    // Bin 0 always seeds the max; afterwards only a strictly larger value wins.
    always_comb begin
        cand_val = run_max;
        cand_bin = run_bin;
        if (range_bin == 10'd0 || pc_abs2 > run_max) begin
            cand_val = pc_abs2;
            cand_bin = range_bin;
        end
    end

    assign result_load = pc_valid && (range_bin == LAST_BIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max    <= '0;
            run_bin    <= '0;
            peak_val   <= '0;
            peak_bin   <= '0;
            peak_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (pc_valid) begin
                run_max <= cand_val;
                run_bin <= cand_bin;
            end
            if (result_load) begin
                peak_val   <= cand_val;
                peak_bin   <= cand_bin;
                peak_valid <= 1'b1;
                if (peak_valid && !peak_ready) overrun <= 1'b1;
            end else if (peak_valid && peak_ready) begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_prt_ctrl.sv
// Randomized bench for pc_prt_ctrl; expectations come from a cycle-indexed model of the
// PRT timeline and a scan of each PRT's power profile for its first maximum.
module tb_pc_prt_ctrl;

    localparam int WIDTH    = 12;
    localparam int TAPS     = 64;
    localparam int ABS_W    = 73;
    localparam int PRT_LEN  = 1000;
    localparam int TX_LEN   = 64;
    localparam int RX_START = 80;
    localparam int RX_LEN   = 512;
    localparam int PC_LAT   = 3;
    localparam int NBINS    = RX_LEN + TAPS - 1;
    localparam int V_START  = RX_START + 1 + PC_LAT;
    localparam int V_END    = V_START + NBINS - 1;
    localparam int FL_START = RX_START + RX_LEN;

    logic             clk, rst, en, peak_ready;
    logic [WIDTH-1:0] adc_I, adc_Q, pc_in_I, pc_in_Q;
    logic [ABS_W-1:0] pc_abs2, peak_val;
    logic             tx_trig, rx_gate, flush, pc_valid, peak_valid, overrun, busy;
    logic [9:0]       range_bin, peak_bin;
    logic [15:0]      prt_index;

    pc_prt_ctrl #(
        .WIDTH(WIDTH), .TAPS(TAPS), .ABS_W(ABS_W), .PRT_LEN(PRT_LEN), .TX_LEN(TX_LEN),
        .RX_START(RX_START), .RX_LEN(RX_LEN), .PC_LAT(PC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .adc_I(adc_I), .adc_Q(adc_Q),
        .pc_in_I(pc_in_I), .pc_in_Q(pc_in_Q), .pc_abs2(pc_abs2),
        .tx_trig(tx_trig), .rx_gate(rx_gate), .flush(flush),
        .pc_valid(pc_valid), .range_bin(range_bin),
        .peak_valid(peak_valid), .peak_ready(peak_ready),
        .peak_val(peak_val), .peak_bin(peak_bin), .prt_index(prt_index),
        .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: mc is the prt_cnt of the cycle visible at the current negedge, -1 when idle.
    int               mc;
    bit               m_valid, m_ovr;
    logic [ABS_W-1:0] m_val;
    int               m_bin, m_index;

    logic [WIDTH-1:0] s_i [RX_LEN];
    logic [WIDTH-1:0] s_q [RX_LEN];
    logic [ABS_W-1:0] s_abs [NBINS];

    function automatic bit in_rng(int c, int lo, int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic logic [WIDTH-1:0] exp_in_i(int c);
        return in_rng(c, RX_START + 1, RX_START + RX_LEN) ? s_i[c - RX_START - 1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_in_q(int c);
        return in_rng(c, RX_START + 1, RX_START + RX_LEN) ? s_q[c - RX_START - 1] : '0;
    endfunction

    function automatic logic [ABS_W-1:0] rand_abs();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) return ABS_W'(r);
        return ABS_W'($urandom_range(0, 40));
    endfunction

    task automatic fill_random();
        for (int k = 0; k < RX_LEN; k++) begin
            s_i[k] = WIDTH'($urandom);
            s_q[k] = WIDTH'($urandom);
        end
        for (int b = 0; b < NBINS; b++) s_abs[b] = rand_abs();
    endtask

    // Inputs outside the windows carry junk so that gating and bin qualification are exercised.
    task automatic drive();
        if (in_rng(mc, RX_START, RX_START + RX_LEN - 1)) begin
            adc_I = s_i[mc - RX_START];
            adc_Q = s_q[mc - RX_START];
        end else begin
            adc_I = WIDTH'($urandom);
            adc_Q = WIDTH'($urandom);
        end
        pc_abs2 = in_rng(mc, V_START, V_END) ? s_abs[mc - V_START] : rand_abs();
    endtask

    task automatic advance();
        logic [ABS_W-1:0] best;
        int               bb;
        if (rst) begin
            mc = -1; m_valid = 0; m_ovr = 0; m_val = '0; m_bin = 0; m_index = 0;
        end else begin
            if (mc == V_END) begin
                best = s_abs[0];
                bb   = 0;
                for (int b = 1; b < NBINS; b++)
                    if (s_abs[b] > best) begin best = s_abs[b]; bb = b; end
                if (m_valid && !peak_ready) m_ovr = 1;
                m_valid = 1; m_val = best; m_bin = bb;
            end else if (m_valid && peak_ready) begin
                m_valid = 0;
            end
            if (mc == -1) mc = en ? 0 : -1;
            else if (mc == PRT_LEN - 1) begin
                m_index = (m_index + 1) % 65536;
                mc = en ? 0 : -1;
            end else mc++;
        end
        @(negedge clk);
    endtask

    task automatic start_prt();
        en = 1'b1;
        drive();
        advance();
    endtask

    task automatic test_reset();
        logic [255:0] all_out;
        rst = 1'b1; en = 1'b0; peak_ready = 1'b0;
        repeat (3) begin drive(); @(negedge clk); end
        all_out = 256'({tx_trig, rx_gate, flush, busy, pc_valid, range_bin, pc_in_I, pc_in_Q,
                        peak_valid, peak_val, peak_bin, prt_index, overrun});
        total++; if (all_out !== '0) $display("[TB] FAIL reset_outputs got %0h want 0", all_out); else passed++;
        advance();
        rst = 1'b0;
        drive(); advance();
        total++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_timing();
        fill_random();
        peak_ready = 1'b1;
        start_prt();
        for (int c = 0; c < PRT_LEN; c++) begin
            total++; if (tx_trig !== in_rng(mc, 0, TX_LEN - 1)) $display("[TB] FAIL tx_trig c=%0d got %b", mc, tx_trig); else passed++;
            total++; if (rx_gate !== in_rng(mc, RX_START, FL_START - 1)) $display("[TB] FAIL rx_gate c=%0d got %b", mc, rx_gate); else passed++;
            total++; if (flush !== in_rng(mc, FL_START, FL_START + TAPS - 2)) $display("[TB] FAIL flush c=%0d got %b", mc, flush); else passed++;
            total++; if (busy !== 1'b1) $display("[TB] FAIL busy c=%0d got %b want 1", mc, busy); else passed++;
            en = (c < PRT_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(); advance();
        end
        total++; if (busy !== 1'b0) $display("[TB] FAIL busy_after_prt got %b want 0", busy); else passed++;
        total++; if (prt_index !== 16'd1) $display("[TB] FAIL prt_index got %0d want 1", prt_index); else passed++;
        drive(); advance();
        total++; if (tx_trig !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL stays_idle got tx=%b busy=%b want 0", tx_trig, busy); else passed++;
    endtask

    task automatic test_gating();
        fill_random();
        for (int k = 0; k < RX_LEN; k++) s_i[k] = '0;
        s_i[0] = 12'd100;
        start_prt();
        for (int c = 0; c < PRT_LEN; c++) begin
            total++; if (pc_in_I !== exp_in_i(mc)) $display("[TB] FAIL pc_in_I c=%0d got %0d want %0d", mc, pc_in_I, exp_in_i(mc)); else passed++;
            total++; if (pc_in_Q !== exp_in_q(mc)) $display("[TB] FAIL pc_in_Q c=%0d got %0d want %0d", mc, pc_in_Q, exp_in_q(mc)); else passed++;
            total++; if (pc_valid !== in_rng(mc, V_START, V_END)) $display("[TB] FAIL pc_valid c=%0d got %b", mc, pc_valid); else passed++;
            total++;
            if (range_bin !== (in_rng(mc, V_START, V_END) ? 10'(mc - V_START) : 10'd0))
                $display("[TB] FAIL range_bin c=%0d got %0d", mc, range_bin);
            else passed++;
            if (mc == 81) begin
                total++; if (pc_in_I !== 12'd100) $display("[TB] FAIL first_sample got %0d want 100", pc_in_I); else passed++;
            end
            if (mc == 658) begin
                total++; if (range_bin !== 10'd574) $display("[TB] FAIL last_bin got %0d want 574", range_bin); else passed++;
            end
            en = (c < PRT_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(); advance();
        end
    endtask

    task automatic test_peak(input logic [ABS_W-1:0] base, input logic [ABS_W-1:0] hi,
                             input int bin_a, input int bin_b, input int exp_bin);
        fill_random();
        for (int b = 0; b < NBINS; b++) s_abs[b] = base;
        s_abs[bin_a] = hi;
        s_abs[bin_b] = hi;
        peak_ready = 1'b1;
        start_prt();
        for (int c = 0; c < PRT_LEN; c++) begin
            total++; if (peak_valid !== m_valid) $display("[TB] FAIL peak_valid c=%0d got %b want %b", mc, peak_valid, m_valid); else passed++;
            if (mc == V_END + 1) begin
                total++; if (peak_val !== hi) $display("[TB] FAIL peak_val got %0d want %0d", peak_val, hi); else passed++;
                total++; if (peak_bin !== 10'(exp_bin)) $display("[TB] FAIL peak_bin got %0d want %0d", peak_bin, exp_bin); else passed++;
            end
            if (mc == V_END + 2) begin
                total++; if (peak_valid !== 1'b0) $display("[TB] FAIL peak_valid_drop got %b want 0", peak_valid); else passed++;
            end
            en = (c < PRT_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(); advance();
        end
    endtask

    task automatic test_back_to_back();
        peak_ready = 1'b0;
        fill_random();
        start_prt();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < PRT_LEN; c++) begin
                if (c == 0 && p == 1) fill_random();
                total++; if (peak_valid !== m_valid) $display("[TB] FAIL b2b_valid c=%0d got %b want %b", mc, peak_valid, m_valid); else passed++;
                total++; if (overrun !== m_ovr) $display("[TB] FAIL b2b_overrun c=%0d got %b want %b", mc, overrun, m_ovr); else passed++;
                if (m_valid) begin
                    total++; if (peak_val !== m_val || peak_bin !== 10'(m_bin))
                        $display("[TB] FAIL b2b_result c=%0d got %0h/%0d want %0h/%0d", mc, peak_val, peak_bin, m_val, m_bin);
                    else passed++;
                end
                peak_ready = (p == 1 && c >= V_END);
                en = (c < PRT_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'(p == 0);
                drive(); advance();
            end
        end
    endtask

    task automatic test_overrun();
        peak_ready = 1'b0;
        fill_random();
        start_prt();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < PRT_LEN; c++) begin
                if (c == 0 && p == 1) fill_random();
                total++; if (peak_valid !== m_valid) $display("[TB] FAIL ovr_valid c=%0d got %b want %b", mc, peak_valid, m_valid); else passed++;
                total++; if (overrun !== m_ovr) $display("[TB] FAIL ovr_flag c=%0d got %b want %b", mc, overrun, m_ovr); else passed++;
                if (m_valid) begin
                    total++; if (peak_val !== m_val || peak_bin !== 10'(m_bin))
                        $display("[TB] FAIL ovr_result c=%0d got %0h/%0d want %0h/%0d", mc, peak_val, peak_bin, m_val, m_bin);
                    else passed++;
                end
                if (p == 1 && mc == V_END + 3) begin
                    total++; if (peak_valid !== 1'b0 || overrun !== 1'b1)
                        $display("[TB] FAIL ovr_after_accept got valid=%b ovr=%b want 0/1", peak_valid, overrun);
                    else passed++;
                end
                peak_ready = (p == 1 && c == V_END + 2);
                en = (c < PRT_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'(p == 0);
                drive(); advance();
            end
        end
        total++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky got %b want 1", overrun); else passed++;
    endtask

    task automatic test_random();
        start_prt();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < PRT_LEN; c++) begin
                if (c == 0) fill_random();
                total++; if (tx_trig !== in_rng(mc, 0, TX_LEN - 1) || rx_gate !== in_rng(mc, RX_START, FL_START - 1) ||
                             flush !== in_rng(mc, FL_START, FL_START + TAPS - 2) || busy !== 1'b1)
                    $display("[TB] FAIL rnd_strobes c=%0d got %b%b%b%b", mc, tx_trig, rx_gate, flush, busy);
                else passed++;
                total++; if (pc_in_I !== exp_in_i(mc) || pc_in_Q !== exp_in_q(mc))
                    $display("[TB] FAIL rnd_gate c=%0d got %0h/%0h want %0h/%0h", mc, pc_in_I, pc_in_Q, exp_in_i(mc), exp_in_q(mc));
                else passed++;
                total++; if (pc_valid !== in_rng(mc, V_START, V_END) ||
                             range_bin !== (in_rng(mc, V_START, V_END) ? 10'(mc - V_START) : 10'd0))
                    $display("[TB] FAIL rnd_bin c=%0d got %b/%0d", mc, pc_valid, range_bin);
                else passed++;
                total++; if (peak_valid !== m_valid || overrun !== m_ovr)
                    $display("[TB] FAIL rnd_hs c=%0d got %b/%b want %b/%b", mc, peak_valid, overrun, m_valid, m_ovr);
                else passed++;
                if (m_valid) begin
                    total++; if (peak_val !== m_val || peak_bin !== 10'(m_bin))
                        $display("[TB] FAIL rnd_result c=%0d got %0h/%0d want %0h/%0d", mc, peak_val, peak_bin, m_val, m_bin);
                    else passed++;
                end
                total++; if (prt_index !== 16'(m_index)) $display("[TB] FAIL rnd_index c=%0d got %0d want %0d", mc, prt_index, m_index); else passed++;
                peak_ready = ($urandom_range(0, 2) == 0);
                en = (c < PRT_LEN - 1) ? 1'($urandom_range(0, 1)) : 1'(p < 2);
                drive(); advance();
            end
        end
    endtask

    task automatic test_abort();
        logic [255:0] all_out;
        peak_ready = 1'b0;
        fill_random();
        start_prt();
        for (int c = 0; c < 400; c++) begin
            en = (c < 200);
            drive(); advance();
        end
        rst = 1'b1;
        drive(); advance();
        all_out = 256'({tx_trig, rx_gate, flush, busy, pc_valid, range_bin, pc_in_I, pc_in_Q,
                        peak_valid, peak_val, peak_bin, prt_index, overrun});
        total++; if (all_out !== '0) $display("[TB] FAIL abort_outputs got %0h want 0", all_out); else passed++;
        rst = 1'b0;
        for (int c = 0; c < 700; c++) begin
            en = 1'b0;
            drive(); advance();
            total++; if (busy !== 1'b0 || peak_valid !== 1'b0 || overrun !== 1'b0)
                $display("[TB] FAIL abort_idle c=%0d got busy=%b valid=%b ovr=%b want 0", c, busy, peak_valid, overrun);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; peak_ready = 1'b0;
        adc_I = '0; adc_Q = '0; pc_abs2 = '0;
        mc = -1; m_valid = 0; m_ovr = 0; m_val = '0; m_bin = 0; m_index = 0;
        test_reset();
        test_timing();
        test_gating();
        test_peak(73'd5, 73'd500, 37, 37, 37);
        test_peak(73'd1, 73'd900, 12, 300, 12);
        test_back_to_back();
        test_overrun();
        test_random();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_prt_ctrl.md
Name: pc_prt_ctrl

Overview:
- Pulse-repetition-interval (PRT) sequencer for the 64-tap I/Q pulse-compression matched filter.
- Generates the transmit trigger and the receive gate, and zero-gates the ADC I/Q stream into the filter. After each receive window it flushes the filter with TAPS-1 zero samples.
- Aligns a per-bin valid and range index with the filter's |y|^2 output, searches each PRT for the peak, and hands the result downstream with a valid/ready handshake.

Parameters:
WIDTH, 12, I/Q sample width (two's complement)
TAPS, 64, matched-filter length
ABS_W, 73, width of filter power output (6*WIDTH+1)
PRT_LEN, 1000, PRT period in clk cycles
TX_LEN, 64, transmit trigger length in cycles
RX_START, 80, prt_cnt value at which the receive window opens
RX_LEN, 512, receive window length in samples
PC_LAT, 3, cycles from pc_in_* to the matching pc_abs2
Legality constraint: TX_LEN <= RX_START, and RX_START+RX_LEN+TAPS+PC_LAT <= PRT_LEN-1. This is checked by elaboration-time assertion.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  run request; sampled every cycle
adc_I  in  WIDTH  ADC I sample, one per cycle
adc_Q  in  WIDTH  ADC Q sample
pc_in_I  out  WIDTH  registered filter input I (gated)
pc_in_Q  out  WIDTH  registered filter input Q (gated)
pc_abs2  in  ABS_W  filter power output, unsigned
tx_trig  out  1  transmit pulse
rx_gate  out  1  receive window active
flush  out  1  filter flush active
pc_valid  out  1  pc_abs2 holds a valid range bin this cycle
range_bin  out  10  bin index for pc_valid (0..RX_LEN+TAPS-2)
peak_valid  out  1  peak result available
peak_ready  in  1  downstream accepts result
peak_val  out  ABS_W  maximum pc_abs2 in PRT
peak_bin  out  10  bin of maximum
prt_index  out  16  completed-PRT counter, wraps 65535->0
overrun  out  1  sticky: a result was overwritten before acceptance
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE. A reset mid-PRT aborts immediately: the in-flight peak search is discarded and any pending result is dropped.
- States: IDLE, TX, GAP, RX, FLUSH, TAIL. A free-running prt_cnt counts 0..PRT_LEN-1 while not IDLE.
- IDLE:
  - prt_cnt=0.
  - If en=1, the next cycle is TX with prt_cnt=0.
- TX: prt_cnt 0..TX_LEN-1; tx_trig=1.
- GAP: prt_cnt TX_LEN..RX_START-1. Skipped if TX_LEN==RX_START.
- RX: prt_cnt RX_START..RX_START+RX_LEN-1; rx_gate=1.
- FLUSH: next TAPS-1 cycles; flush=1.
- TAIL: remaining cycles to PRT_LEN-1.
- At prt_cnt==PRT_LEN-1:
  - prt_index increments.
  - If en=1, go to TX with prt_cnt=0. Otherwise go to IDLE.
  - Deasserting en never truncates a PRT.
- tx_trig, rx_gate, flush and busy are registered decodes of the current state. They are high on exactly the prt_cnt cycles listed above.
- Input gating: pc_in_* <= adc_* when state==RX, else 0. This adds one register stage. RX sample k (taken at prt_cnt=RX_START+k) appears on pc_in_* at prt_cnt=RX_START+1+k.
- Bin alignment:
  - NBINS = RX_LEN+TAPS-1.
  - Bin b (0..NBINS-1) corresponds to pc_in_* at prt_cnt=RX_START+1+b.
  - pc_valid=1 with range_bin=b at prt_cnt=RX_START+1+b+PC_LAT. Otherwise pc_valid=0 and range_bin=0.
- Peak search:
  - On pc_valid with b==0, the running max is loaded unconditionally.
  - Thereafter it updates only on strictly greater pc_abs2, so the first maximum wins ties.
  - pc_abs2 is compared unsigned.
- Result register:
  - On the cycle after the last valid bin (b=NBINS-1), peak_val/peak_bin are loaded and peak_valid rises.
  - peak_valid holds, with stable data, until a cycle where peak_valid&&peak_ready; it clears on the next cycle.
  - If a new result loads while peak_valid=1 and peak_ready=0, the data is overwritten, peak_valid stays 1 and overrun is set. overrun clears only on rst.
  - Handshake and load in the same cycle: the old result is transferred, the new one is loaded, peak_valid stays 1, and overrun is not set.
- With the legality constraint, the last valid bin lands no later than prt_cnt=PRT_LEN-2. A full PRT's result is therefore always produced before IDLE/next TX.

Test Plan:
1. Reset then en=1 for one PRT (defaults) -> tx_trig high prt_cnt 0..63; rx_gate 80..591; flush 592..654; back to IDLE after cycle 999; prt_index=1.
2. adc_I=100 at RX sample 0, other samples 0 -> pc_in_I=100 exactly at prt_cnt 81, 0 elsewhere; pc_valid first high at prt_cnt 84 with range_bin 0, last at prt_cnt 658 with range_bin 574.
3. Bench drives pc_abs2=5 everywhere except 500 during range_bin 37, peak_ready=1 -> peak_val=500, peak_bin=37, peak_valid high for 1 cycle at prt_cnt 659.
4. pc_abs2=900 at bins 12 and 300, else 1 -> peak_bin=12.
5. peak_ready=0 across two PRTs -> result of PRT 2 visible, overrun=1. Then peak_ready=1 -> peak_valid falls next cycle; overrun stays 1 until rst.
6. en dropped at prt_cnt 200, then rst pulsed at prt_cnt 400 -> all outputs 0 the next cycle, no result produced, state IDLE.
